// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Request/response bundle between the two ALU requesters (pipeline issue
//   logic = requester 0, address/branch unit = requester 1), the response
//   consumer, and the alu_arbiter.
//
//   Request side  : req_valid[1:0], req_ready[1:0], per-requester opcode,
//                   operand a, register operand b, immediate, and alu_src bit.
//   Response side : resp_valid/resp_ready handshake with resp_id, resp_result
//                   and resp_zero.
//
//   modport master : requesters + response consumer
//   modport slave  : the arbiter
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [2:0]            req_op0;
  logic [2:0]            req_op1;
  logic [DATA_WIDTH-1:0] req_a0;
  logic [DATA_WIDTH-1:0] req_a1;
  logic [DATA_WIDTH-1:0] req_b0;
  logic [DATA_WIDTH-1:0] req_b1;
  logic [DATA_WIDTH-1:0] req_imm0;
  logic [DATA_WIDTH-1:0] req_imm1;
  logic [1:0]            req_alu_src;

  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_id;
  logic [DATA_WIDTH-1:0] resp_result;
  logic                  resp_zero;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
           req_imm0, req_imm1, req_alu_src, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_zero
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
           req_imm0, req_imm1, req_alu_src, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester round-robin arbiter and sequencer for the shared
//   execute-stage ALU. One operation is in flight at a time:
//     IDLE : grant one valid requester (tie -> the one not served last),
//            latch its payload into the operand registers.
//     EXEC : operand registers drive the ALU; its combinational result and
//            zero flag are captured at the end of the cycle.
//     RESP : captured response held on resp_* until resp_ready.
//   Peak throughput is one operation every three cycles.
//
//   Ports
//     clk, rst        : clock (rising edge), synchronous active-high reset
//     bus (slave)     : request/response bundle, see alu_arbiter_if
//     alu_reg_data1   : operand a to the ALU
//     alu_reg_data2   : register operand b to the ALU
//     alu_imm         : immediate to the ALU
//     alu_alu_src     : 1 -> ALU uses alu_imm as second operand
//     alu_op          : 3-bit ALU opcode (passed through unchanged)
//     alu_result      : combinational ALU result
//     alu_zero        : combinational ALU zero flag
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_arbiter_if.slave          bus,
  output logic [DATA_WIDTH-1:0] alu_reg_data1,
  output logic [DATA_WIDTH-1:0] alu_reg_data2,
  output logic [DATA_WIDTH-1:0] alu_imm,
  output logic                  alu_alu_src,
  output logic [2:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Requester served most recently; reset to 1 so requester 0 wins the
  // first tie.
  logic last_q;

  logic grant_vld;
  logic grant_id;
  logic accept;

  // Payload of the granted requester, selected ahead of the operand registers.
  logic [2:0]            op_sel;
  logic [DATA_WIDTH-1:0] a_sel;
  logic [DATA_WIDTH-1:0] b_sel;
  logic [DATA_WIDTH-1:0] imm_sel;
  logic                  src_sel;

  // Operand registers (stage 0) and captured response (stage 1).
  logic [2:0]            op_p0;
  logic [DATA_WIDTH-1:0] a_p0;
  logic [DATA_WIDTH-1:0] b_p0;
  logic [DATA_WIDTH-1:0] imm_p0;
  logic                  src_p0;
  logic                  id_p0;
  logic [DATA_WIDTH-1:0] result_p1;
  logic                  zero_p1;

  // ------------------------------------------------------------------
  // Control: grant, handshake and next state
  // ------------------------------------------------------------------
  // req_ready depends only on state, last_q, req_valid (and rst), never on
  // resp_ready or the ALU outputs.
  always_comb begin
    state_d       = state_q;
    grant_vld     = 1'b0;
    grant_id      = 1'b0;
    accept        = 1'b0;
    bus.req_ready = 2'b00;

    unique case (state_q)
      IDLE: begin
        unique case (bus.req_valid)
          2'b01: begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
          end
          2'b10: begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
          end
          2'b11: begin
            grant_vld = 1'b1;
            grant_id  = ~last_q;
          end
          default: begin
            grant_vld = 1'b0;
            grant_id  = 1'b0;
          end
        endcase

        if (grant_vld && !rst) begin
          bus.req_ready = grant_id ? 2'b10 : 2'b01;
          accept        = 1'b1;
          state_d       = EXEC;
        end
      end

      EXEC: begin
        state_d = RESP;
      end

      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q <= grant_id;
      end
    end
  end

  always_comb begin
    op_sel  = grant_id ? bus.req_op1  : bus.req_op0;
    a_sel   = grant_id ? bus.req_a1   : bus.req_a0;
    b_sel   = grant_id ? bus.req_b1   : bus.req_b0;
    imm_sel = grant_id ? bus.req_imm1 : bus.req_imm0;
    src_sel = bus.req_alu_src[grant_id];
  end

  // ------------------------------------------------------------------
  // Stage 0: operand registers, loaded on accept
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_p0  <= 3'b000;
      a_p0   <= '0;
      b_p0   <= '0;
      imm_p0 <= '0;
      src_p0 <= 1'b0;
      id_p0  <= 1'b0;
    end else if (accept) begin
      op_p0  <= op_sel;
      a_p0   <= a_sel;
      b_p0   <= b_sel;
      imm_p0 <= imm_sel;
      src_p0 <= src_sel;
      id_p0  <= grant_id;
    end
  end

  // The ALU always sees the operand registers, so its inputs hold their last
  // values outside EXEC and only the EXEC-cycle result is ever captured.
  assign alu_op        = op_p0;
  assign alu_reg_data1 = a_p0;
  assign alu_reg_data2 = b_p0;
  assign alu_imm       = imm_p0;
  assign alu_alu_src   = src_p0;

  // ------------------------------------------------------------------
  // Stage 1: response capture at the end of EXEC
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      result_p1 <= '0;
      zero_p1   <= 1'b0;
    end else if (state_q == EXEC) begin
      result_p1 <= alu_result;
      zero_p1   <= alu_zero;
    end
  end

  assign bus.resp_valid  = (state_q == RESP);
  assign bus.resp_id     = id_p0;
  assign bus.resp_result = result_p1;
  assign bus.resp_zero   = zero_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Bench for alu_arbiter: a behavioural ALU stands in for the real one, a
//   per-operation reference model predicts grants, handshake and responses,
//   directed scenarios cover the main cases, then randomized traffic runs.
module tb_alu_arbiter;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  logic [DW-1:0] alu_reg_data1;
  logic [DW-1:0] alu_reg_data2;
  logic [DW-1:0] alu_imm;
  logic          alu_alu_src;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_result;
  logic          alu_zero;

  alu_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .alu_reg_data1 (alu_reg_data1),
    .alu_reg_data2 (alu_reg_data2),
    .alu_imm       (alu_imm),
    .alu_alu_src   (alu_alu_src),
    .alu_op        (alu_op),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero)
  );

  function automatic logic [DW-1:0] alu_ref(input logic [2:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      default: return DW'(0);
    endcase
  endfunction

  // Stand-in ALU
  always_comb begin
    alu_result = alu_ref(alu_op, alu_reg_data1, alu_alu_src ? alu_imm : alu_reg_data2);
    alu_zero   = (alu_result == '0);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Requester-side stimulus state
  logic [1:0]    rv;
  logic [2:0]    rop  [2];
  logic [DW-1:0] ra   [2];
  logic [DW-1:0] rb   [2];
  logic [DW-1:0] rimm [2];
  logic [1:0]    rsrc;
  logic          rresp_ready;

  // Reference model: phase 0 = free, 1 = operation executing, 2 = response held
  int            m_phase;
  logic          m_last;
  logic          m_id;
  logic [2:0]    m_op;
  logic [DW-1:0] m_a, m_b, m_imm, m_result;
  logic          m_src, m_zero;

  int cyc;
  int lg;   // requester accepted in the most recent cycle, -1 if none

  logic [2:0] op_tab [8];

  task automatic model_reset();
    m_phase  = 0;
    m_last   = 1'b1;
    m_id     = 1'b0;
    m_op     = 3'b000;
    m_a      = '0;
    m_b      = '0;
    m_imm    = '0;
    m_src    = 1'b0;
    m_result = '0;
    m_zero   = 1'b0;
  endtask

  function automatic int model_grant();
    if (rst || m_phase != 0) return -1;
    if (rv == 2'b11)         return m_last ? 0 : 1;
    if (rv[0])               return 0;
    if (rv[1])               return 1;
    return -1;
  endfunction

  task automatic drive();
    bus.req_valid   = rv;
    bus.req_op0     = rop[0];
    bus.req_op1     = rop[1];
    bus.req_a0      = ra[0];
    bus.req_a1      = ra[1];
    bus.req_b0      = rb[0];
    bus.req_b1      = rb[1];
    bus.req_imm0    = rimm[0];
    bus.req_imm1    = rimm[1];
    bus.req_alu_src = rsrc;
    bus.resp_ready  = rresp_ready;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] imm, input logic src);
    rop[i]  = op;
    ra[i]   = a;
    rb[i]   = b;
    rimm[i] = imm;
    rsrc[i] = src;
    rv[i]   = 1'b1;
  endtask

  function automatic logic [DW-1:0] rand_val();
    if ($urandom_range(0, 2) == 0) return DW'($urandom_range(0, 3));
    return DW'($urandom);
  endfunction

  task automatic rand_req(input int i);
    set_req(i, op_tab[$urandom_range(0, 7)], rand_val(), rand_val(), rand_val(),
            1'($urandom_range(0, 1)));
  endtask

  // One clock cycle: called just after a falling edge with stimulus set up.
  task automatic cycle();
    int g;
    logic [1:0] exp_ready;
    drive();
    #1;
    g = model_grant();
    exp_ready = (g < 0) ? 2'b00 : (g == 1 ? 2'b10 : 2'b01);
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    lg = -1;
    if (rst) begin
      model_reset();
    end else if (g >= 0) begin
      m_op    = rop[g];
      m_a     = ra[g];
      m_b     = rb[g];
      m_imm   = rimm[g];
      m_src   = rsrc[g];
      m_id    = 1'(g);
      m_last  = 1'(g);
      m_phase = 1;
      rv[g]   = 1'b0;
      lg      = g;
    end else if (m_phase == 1) begin
      m_result = alu_ref(m_op, m_a, m_src ? m_imm : m_b);
      m_zero   = (m_result == '0);
      m_phase  = 2;
    end else if (m_phase == 2 && rresp_ready) begin
      m_phase = 0;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("resp_valid",  64'(bus.resp_valid),  64'(m_phase == 2));
    check("resp_id",     64'(bus.resp_id),     64'(m_id));
    check("resp_result", 64'(bus.resp_result), 64'(m_result));
    check("resp_zero",   64'(bus.resp_zero),   64'(m_zero));
    check("alu_op",      64'(alu_op),          64'(m_op));
    check("alu_a",       64'(alu_reg_data1),   64'(m_a));
    check("alu_b",       64'(alu_reg_data2),   64'(m_b));
    check("alu_imm",     64'(alu_imm),         64'(m_imm));
    check("alu_src",     64'(alu_alu_src),     64'(m_src));
  endtask

  task automatic drain();
    rv          = 2'b00;
    rresp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (m_phase == 0) break;
      cycle();
    end
    check("drain_idle", 64'(bus.resp_valid), 64'(0));
  endtask

  int fair_g[$];
  int fair_c[$];

  initial begin
    op_tab = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011, 3'b100, 3'b101};
    rv = 2'b00;
    rsrc = 2'b00;
    rresp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rop[i] = 3'b000; ra[i] = '0; rb[i] = '0; rimm[i] = '0;
    end
    cyc = 0;
    lg = -1;
    model_reset();
    rst = 1'b1;
    drive();
    @(negedge clk);

    // Reset
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    check("rst_resp_result", 64'(bus.resp_result), 64'(0));

    // Single ADD from requester 0: 5 + 7
    set_req(0, 3'b010, 32'd5, 32'd7, 32'd100, 1'b0);
    rresp_ready = 1'b0;
    cycle();
    check("single_grant", 64'(lg), 64'(0));
    cycle();
    check("single_valid",  64'(bus.resp_valid),  64'(1));
    check("single_id",     64'(bus.resp_id),     64'(0));
    check("single_result", 64'(bus.resp_result), 64'(12));
    check("single_zero",   64'(bus.resp_zero),   64'(0));
    rresp_ready = 1'b1;
    cycle();

    // SUB with immediate from requester 1: 9 - 9 = 0
    set_req(1, 3'b110, 32'd9, 32'd3, 32'd9, 1'b1);
    rresp_ready = 1'b0;
    cycle();
    cycle();
    check("imm_result", 64'(bus.resp_result), 64'(0));
    check("imm_zero",   64'(bus.resp_zero),   64'(1));
    check("imm_id",     64'(bus.resp_id),     64'(1));

    // Backpressure for 5 cycles with requester 0 waiting (SLT 2 < 3)
    set_req(0, 3'b111, 32'd2, 32'd3, 32'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("bp_valid",  64'(bus.resp_valid),  64'(1));
      check("bp_result", 64'(bus.resp_zero),   64'(1));
    end
    rresp_ready = 1'b1;
    cycle();
    cycle();
    check("bp_accept", 64'(lg), 64'(0));
    rresp_ready = 1'b0;
    cycle();
    check("slt_result", 64'(bus.resp_result), 64'(1));
    check("slt_id",     64'(bus.resp_id),     64'(0));
    rresp_ready = 1'b1;
    cycle();

    // Tie fairness: both requesters continuously valid
    rand_req(0);
    rand_req(1);
    for (int k = 0; k < 15; k++) begin
      cycle();
      if (lg >= 0) begin
        fair_g.push_back(lg);
        fair_c.push_back(cyc);
      end
      for (int i = 0; i < 2; i++) if (!rv[i]) rand_req(i);
    end
    check("fair_count", 64'(fair_g.size() >= 4), 64'(1));
    if (fair_g.size() > 0) check("fair_first", 64'(fair_g[0]), 64'(1));
    for (int k = 1; k < fair_g.size(); k++) begin
      check("fair_alt", 64'(fair_g[k]), 64'(1 - fair_g[k-1]));
      check("fair_gap", 64'(fair_c[k] - fair_c[k-1]), 64'(3));
    end

    // Reset during EXEC
    drain();
    rand_req(0);
    rand_req(1);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_valid",  64'(bus.resp_valid),  64'(0));
    check("mid_rst_alu_op", 64'(alu_op),          64'(0));
    check("mid_rst_result", 64'(bus.resp_result), 64'(0));
    for (int i = 0; i < 2; i++) if (!rv[i]) rand_req(i);
    cycle();
    check("post_rst_grant", 64'(lg), 64'(0));

    // Illegal opcode 3'b011
    drain();
    set_req(1, 3'b011, 32'h1234_5678, 32'h0000_00ff, 32'd7, 1'b0);
    cycle();
    cycle();
    check("ill_valid",  64'(bus.resp_valid),  64'(1));
    check("ill_result", 64'(bus.resp_result), 64'(0));
    check("ill_zero",   64'(bus.resp_zero),   64'(1));
    cycle();
    check("ill_done", 64'(bus.resp_valid), 64'(0));

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++)
        if (!rv[i] && $urandom_range(0, 2) == 0) rand_req(i);
      rresp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
